// File: rtl/msfsm_fire_scheduler_if.sv
// Scheduler <-> net bundle for msfsm_fire_scheduler.
// master: environment/net side (drives req, enabled; observes fire status).
// slave : scheduler side (samples req, enabled; drives fire, fire_idx, busy,
//         deadlock, fire_count).
interface msfsm_fire_scheduler_if #(
    parameter int unsigned N_T   = 8,
    parameter int unsigned CNT_W = 16
) ();
    localparam int unsigned IDX_W = (N_T > 1) ? $clog2(N_T) : 1;

    logic [N_T-1:0]   req;
    logic [N_T-1:0]   enabled;
    logic [N_T-1:0]   fire;
    logic [IDX_W-1:0] fire_idx;
    logic             busy;
    logic             deadlock;
    logic [CNT_W-1:0] fire_count;

    modport master (
        output req,
        output enabled,
        input  fire,
        input  fire_idx,
        input  busy,
        input  deadlock,
        input  fire_count
    );

    modport slave (
        input  req,
        input  enabled,
        output fire,
        output fire_idx,
        output busy,
        output deadlock,
        output fire_count
    );
endinterface

// File: rtl/msfsm_fire_scheduler.sv
// Round-robin transition fire scheduler for synchronous Mealy MSFSMs derived
// from a free-choice Petri net. At most one transition fires per step; each
// fire is a one-cycle one-hot strobe followed by a SETTLE-cycle quiet window
// so MSFSM states and sync outputs can update before the next decision.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   step   - (only with MSFSM_SCHED_STEP_EN) single-step qualifier for firing
//   bus    - slave modport: req/enabled in; fire, fire_idx, busy, deadlock,
//            fire_count out
//
// Optional feature macro: MSFSM_SCHED_STEP_EN (adds the step input).
module msfsm_fire_scheduler #(
    parameter int unsigned N_T    = 8,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef MSFSM_SCHED_STEP_EN
    input  logic                   step,
`endif
    msfsm_fire_scheduler_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(N_T);
    localparam int unsigned SET_W = 4;
    localparam logic [IDX_W:0]   NT_V   = (IDX_W+1)'(N_T);
    localparam logic [IDX_W-1:0] LAST_T = IDX_W'(N_T - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FIRE   = 2'd1;
    localparam logic [1:0] SETTLE_ST = 2'd2;

    logic [1:0]       state,      state_nxt;
    logic [N_T-1:0]   fire_q,     fire_nxt;
    logic [IDX_W-1:0] idx_q,      idx_nxt;
    logic [IDX_W-1:0] ptr,        ptr_nxt;
    logic [SET_W-1:0] settle_cnt, settle_nxt;
    logic             dl_q,       dl_nxt;
    logic [CNT_W-1:0] cnt_q,      cnt_nxt;

    logic [N_T-1:0]   cand;
    logic [N_T-1:0]   rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] sel;
    logic             go;

    // Round-robin pick: rotate candidates so bit 0 is at ptr, take the lowest
    // set bit, then map the offset back to an absolute transition index.
    always_comb begin
        cand = bus.req & bus.enabled;
        rot  = N_T'({cand, cand} >> ptr);
        off  = '0;
        for (int i = N_T - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NT_V) sum = sum - NT_V;
        sel = sum[IDX_W-1:0];
`ifdef MSFSM_SCHED_STEP_EN
        go  = (cand != '0) && step;
`else
        go  = (cand != '0);
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt  = state;
        fire_nxt   = '0;
        idx_nxt    = idx_q;
        ptr_nxt    = ptr;
        settle_nxt = settle_cnt;
        dl_nxt     = dl_q;
        cnt_nxt    = cnt_q;
        case (state)
            IDLE: begin
                // deadlock is only re-evaluated while idle; held otherwise
                dl_nxt = (bus.enabled == '0);
                if (go) begin
                    fire_nxt  = N_T'(1) << sel;
                    idx_nxt   = sel;
                    ptr_nxt   = (sel == LAST_T) ? '0 : sel + IDX_W'(1);
                    cnt_nxt   = cnt_q + CNT_W'(1);
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                if (SETTLE == 0) begin
                    state_nxt = IDLE;
                end else begin
                    settle_nxt = SET_W'(SETTLE - 1);
                    state_nxt  = SETTLE_ST;
                end
            end
            SETTLE_ST: begin
                if (settle_cnt == '0) state_nxt = IDLE;
                else                  settle_nxt = settle_cnt - SET_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset overrides any in-flight fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fire_q     <= '0;
            idx_q      <= '0;
            ptr        <= '0;
            settle_cnt <= '0;
            dl_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state      <= state_nxt;
            fire_q     <= fire_nxt;
            idx_q      <= idx_nxt;
            ptr        <= ptr_nxt;
            settle_cnt <= settle_nxt;
            dl_q       <= dl_nxt;
            cnt_q      <= cnt_nxt;
        end
    end

    assign bus.fire       = fire_q;
    assign bus.fire_idx   = idx_q;
    assign bus.deadlock   = dl_q;
    assign bus.fire_count = cnt_q;
    // Pure decode of the state register.
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_msfsm_fire_scheduler.sv
// Directed testbench for msfsm_fire_scheduler: main instance (N_T=8,
// SETTLE=1, CNT_W=16) and a wrap instance (N_T=8, SETTLE=0, CNT_W=4).
module tb_msfsm_fire_scheduler;
    logic clk;
    logic reset;
`ifdef MSFSM_SCHED_STEP_EN
    logic step;
`endif
    int total;
    int bad;

    msfsm_fire_scheduler_if #(.N_T(8), .CNT_W(16)) bus  ();
    msfsm_fire_scheduler_if #(.N_T(8), .CNT_W(4))  busw ();

    msfsm_fire_scheduler #(.N_T(8), .SETTLE(1), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MSFSM_SCHED_STEP_EN
        .step  (step),
`endif
        .bus   (bus.slave)
    );

    msfsm_fire_scheduler #(.N_T(8), .SETTLE(0), .CNT_W(4)) dut_w (
        .clk   (clk),
        .reset (reset),
`ifdef MSFSM_SCHED_STEP_EN
        .step  (step),
`endif
        .bus   (busw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 8'hFF;  bus.enabled = 8'hFF;
        busw.req = 8'h00; busw.enabled = 8'h00;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (bus.fire !== 8'h00) begin bad++; $display("FAIL reset_fire got=%h exp=00", bus.fire); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
            total++; if (bus.fire_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.fire_count); end
            total++; if (bus.deadlock !== 1'b0) begin bad++; $display("FAIL reset_deadlock got=%b exp=0", bus.deadlock); end
            total++; if (bus.fire_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus.fire_idx); end
        end
        bus.req = 8'h00;
        reset = 1'b0;
        tick();
        total++; if (bus.fire !== 8'h00) begin bad++; $display("FAIL post_reset_fire got=%h exp=00", bus.fire); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.fire_count !== 16'd0) begin bad++; $display("FAIL post_reset_count got=%0d exp=0", bus.fire_count); end
        total++; if (bus.deadlock !== 1'b0) begin bad++; $display("FAIL post_reset_deadlock got=%b exp=0", bus.deadlock); end
        total++; if (busw.fire_count !== 4'd0) begin bad++; $display("FAIL reset_w_count got=%0d exp=0", busw.fire_count); end
    endtask

    // req=05: fires t0, t2, t0, t2 at ticks 1, 4, 7, 10.
    task automatic test_round_robin();
        logic [7:0] exp_f;
        logic       exp_b;
        bus.req = 8'h05; bus.enabled = 8'hFF;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t % 3 == 1) exp_f = (((t - 1) / 3) % 2 == 0) ? 8'h01 : 8'h04;
            else            exp_f = 8'h00;
            exp_b = (t % 3 != 0);
            total++; if (bus.fire !== exp_f) begin bad++; $display("FAIL rr_fire t=%0d got=%h exp=%h", t, bus.fire, exp_f); end
            total++; if (bus.busy !== exp_b) begin bad++; $display("FAIL rr_busy t=%0d got=%b exp=%b", t, bus.busy, exp_b); end
        end
        total++; if (bus.fire_count !== 16'd4) begin bad++; $display("FAIL rr_count got=%0d exp=4", bus.fire_count); end
        bus.req = 8'h00;
    endtask

    // Only t4 is enabled; it must be the only bit that ever fires.
    task automatic test_enable_mask();
        logic [7:0] exp_f;
        bus.req = 8'hFF; bus.enabled = 8'h10;
        for (int t = 1; t <= 9; t++) begin
            tick();
            exp_f = (t % 3 == 1) ? 8'h10 : 8'h00;
            total++; if (bus.fire !== exp_f) begin bad++; $display("FAIL mask_fire t=%0d got=%h exp=%h", t, bus.fire, exp_f); end
            if (t % 3 == 1) begin
                total++; if (bus.fire_idx !== 3'd4) begin bad++; $display("FAIL mask_idx t=%0d got=%0d exp=4", t, bus.fire_idx); end
            end
        end
        total++; if (bus.fire_count !== 16'd7) begin bad++; $display("FAIL mask_count got=%0d exp=7", bus.fire_count); end
        bus.req = 8'h00; bus.enabled = 8'hFF;
    endtask

    task automatic test_deadlock();
        bus.req = 8'hFF; bus.enabled = 8'h00;
        tick();
        total++; if (bus.deadlock !== 1'b1) begin bad++; $display("FAIL dl_set got=%b exp=1", bus.deadlock); end
        total++; if (bus.fire !== 8'h00) begin bad++; $display("FAIL dl_fire got=%h exp=00", bus.fire); end
        bus.req = 8'h02; bus.enabled = 8'h02;
        tick();
        total++; if (bus.deadlock !== 1'b0) begin bad++; $display("FAIL dl_clear got=%b exp=0", bus.deadlock); end
        total++; if (bus.fire !== 8'h02) begin bad++; $display("FAIL dl_fire2 got=%h exp=02", bus.fire); end
        total++; if (bus.fire_idx !== 3'd1) begin bad++; $display("FAIL dl_idx got=%0d exp=1", bus.fire_idx); end
        // enabled drops while busy: deadlock holds until back in IDLE
        bus.req = 8'h00; bus.enabled = 8'h00;
        tick();
        total++; if (bus.deadlock !== 1'b0) begin bad++; $display("FAIL dl_hold1 got=%b exp=0", bus.deadlock); end
        tick();
        total++; if (bus.deadlock !== 1'b0) begin bad++; $display("FAIL dl_hold2 got=%b exp=0", bus.deadlock); end
        tick();
        total++; if (bus.deadlock !== 1'b1) begin bad++; $display("FAIL dl_idle_set got=%b exp=1", bus.deadlock); end
        bus.enabled = 8'hFF;
        tick();
        total++; if (bus.deadlock !== 1'b0) begin bad++; $display("FAIL dl_noreq got=%b exp=0", bus.deadlock); end
        total++; if (bus.fire !== 8'h00) begin bad++; $display("FAIL dl_noreq_fire got=%h exp=00", bus.fire); end
        total++; if (bus.fire_count !== 16'd8) begin bad++; $display("FAIL dl_count got=%0d exp=8", bus.fire_count); end
    endtask

    task automatic test_reset_mid();
        bus.req = 8'h08; bus.enabled = 8'hFF;
        tick();
        total++; if (bus.fire !== 8'h08) begin bad++; $display("FAIL mid_t3 got=%h exp=08", bus.fire); end
        reset = 1'b1;
        tick();
        total++; if (bus.fire !== 8'h00) begin bad++; $display("FAIL mid_fire got=%h exp=00", bus.fire); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.fire_count !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", bus.fire_count); end
        reset = 1'b0;
        bus.req = 8'h09;
        tick();
        total++; if (bus.fire !== 8'h01) begin bad++; $display("FAIL mid_ptr got=%h exp=01", bus.fire); end
        total++; if (bus.fire_count !== 16'd1) begin bad++; $display("FAIL mid_count1 got=%0d exp=1", bus.fire_count); end
        bus.req = 8'h00;
        tick();
        tick();
    endtask

    // SETTLE=0, CNT_W=4: fire n lands at tick 2n-1, count = n mod 16.
    task automatic test_wrap();
        logic [7:0] exp_f;
        logic [3:0] exp_c;
        busw.req = 8'h80; busw.enabled = 8'h80;
        for (int t = 1; t <= 32; t++) begin
            tick();
            exp_f = (t % 2 == 1) ? 8'h80 : 8'h00;
            total++; if (busw.fire !== exp_f) begin bad++; $display("FAIL wrap_fire t=%0d got=%h exp=%h", t, busw.fire, exp_f); end
            if (t % 2 == 1) begin
                exp_c = 4'((t + 1) / 2);
                total++; if (busw.fire_count !== exp_c) begin bad++; $display("FAIL wrap_count t=%0d got=%0d exp=%0d", t, busw.fire_count, exp_c); end
            end
        end
        busw.req = 8'h00;
        tick();
    endtask

`ifdef MSFSM_SCHED_STEP_EN
    task automatic test_step();
        step = 1'b0;
        bus.req = 8'h01; bus.enabled = 8'hFF;
        for (int t = 0; t < 4; t++) begin
            tick();
            total++; if (bus.fire !== 8'h00) begin bad++; $display("FAIL step0_fire t=%0d got=%h exp=00", t, bus.fire); end
        end
        step = 1'b1;
        tick();
        total++; if (bus.fire !== 8'h01) begin bad++; $display("FAIL step1_fire got=%h exp=01", bus.fire); end
        step = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            total++; if (bus.fire !== 8'h00) begin bad++; $display("FAIL step_after t=%0d got=%h exp=00", t, bus.fire); end
        end
        total++; if (bus.fire_count !== 16'd2) begin bad++; $display("FAIL step_count got=%0d exp=2", bus.fire_count); end
        bus.req = 8'h00;
        step = 1'b1;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
`ifdef MSFSM_SCHED_STEP_EN
        step  = 1'b1;
`endif
        bus.req  = 8'h00; bus.enabled  = 8'h00;
        busw.req = 8'h00; busw.enabled = 8'h00;
        test_reset();
        test_round_robin();
        test_enable_mask();
        test_deadlock();
        test_reset_mid();
        test_wrap();
`ifdef MSFSM_SCHED_STEP_EN
        test_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
